// File: rtl/ethernet_stats_counters_if.sv
// ---------------------------------------------------------------------------
// ethernet_stats_counters_if
// Bus bundle between the MAC-status statistics block and its user.
//   event_in      : per-event single-cycle status pulses
//   clear_all     : synchronous clear of all counters and overflow flags
//   rd_en/rd_addr : read request strobe and address
//   rd_data       : read result, qualified by rd_valid
//   overflow      : sticky per-counter overflow/saturation flags
//   activity_led  : stretched activity indicator
// master = block user (MAC wrapper / MMIO side), slave = statistics block.
// ---------------------------------------------------------------------------
interface ethernet_stats_counters_if #(
   parameter int unsigned NUM_EVENTS    = 9,
   parameter int unsigned COUNTER_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH    = 4
);
   logic [NUM_EVENTS-1:0]    event_in;
   logic                     clear_all;
   logic                     rd_en;
   logic [ADDR_WIDTH-1:0]    rd_addr;
   logic [COUNTER_WIDTH-1:0] rd_data;
   logic                     rd_valid;
   logic [NUM_EVENTS-1:0]    overflow;
   logic                     activity_led;

   modport master (
      output event_in, clear_all, rd_en, rd_addr,
      input  rd_data, rd_valid, overflow, activity_led
   );

   modport slave (
      input  event_in, clear_all, rd_en, rd_addr,
      output rd_data, rd_valid, overflow, activity_led
   );
endinterface

// File: rtl/ethernet_stats_counters.sv
// ---------------------------------------------------------------------------
// ethernet_stats_counters
// Accumulates MAC status pulses into per-event counters, exposes them through
// a 1-cycle-latency addressed read port (optional clear-on-read), keeps
// sticky overflow flags and drives a pulse-stretched activity LED.
// Ports:
//   clock125 : block clock (125 MHz MAC domain)
//   reset    : asynchronous active-high reset
//   bus      : ethernet_stats_counters_if.slave (events, clear, read port,
//              overflow flags, activity LED)
// ---------------------------------------------------------------------------
module ethernet_stats_counters #(
   parameter int unsigned NUM_EVENTS    = 9,
   parameter int unsigned COUNTER_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH    = 4,
   parameter bit          SATURATE      = 1'b1,
   parameter bit          CLEAR_ON_READ = 1'b0,
   parameter logic [31:0] LED_MASK      = 32'h0000_0104,
   parameter int unsigned LED_STRETCH   = 6250000
) (
   input  logic                    clock125,
   input  logic                    reset,
   ethernet_stats_counters_if.slave bus
);

   localparam int unsigned             STRETCH_W = $clog2(LED_STRETCH + 1);
   localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [NUM_EVENTS-1:0]    EV_MASK  = LED_MASK[NUM_EVENTS-1:0];
   localparam logic [ADDR_WIDTH-1:0]    OVF_ADDR = ADDR_WIDTH'(NUM_EVENTS);

   logic [COUNTER_WIDTH-1:0] r_cnt      [NUM_EVENTS];
   logic [COUNTER_WIDTH-1:0] w_cnt_next [NUM_EVENTS];
   logic [NUM_EVENTS-1:0]    r_ovf;
   logic [NUM_EVENTS-1:0]    w_ovf_next;
   logic [NUM_EVENTS-1:0]    w_ovf_set;
   logic                     w_ovf_rd_clr;
   logic [COUNTER_WIDTH-1:0] r_rd_data;
   logic [COUNTER_WIDTH-1:0] w_rd_mux;
   logic                     r_rd_valid;
   logic [STRETCH_W-1:0]     r_stretch;
   logic [STRETCH_W-1:0]     w_stretch_next;
   logic                     r_led;

   // Counter update: load (clear_all / clear-on-read), then increment, then
   // saturate or wrap. Loading to zero before the increment keeps a same-cycle
   // event, so a cleared counter with an event lands on 1.
   always_comb begin
      w_ovf_set = '0;
      for (int i = 0; i < NUM_EVENTS; i++) begin
         w_cnt_next[i] = r_cnt[i];
         if (bus.clear_all ||
             (CLEAR_ON_READ && bus.rd_en && (bus.rd_addr == ADDR_WIDTH'(i)))) begin
            w_cnt_next[i] = '0;
         end
         if (bus.event_in[i]) begin
            if (w_cnt_next[i] == CNT_MAX) begin
               w_ovf_set[i]  = 1'b1;
               w_cnt_next[i] = SATURATE ? CNT_MAX : '0;
            end else begin
               w_cnt_next[i] = w_cnt_next[i] + COUNTER_WIDTH'(1);
            end
         end
      end
   end

   // Sticky overflow flags; a clearing read of the flag vector keeps bits
   // that are being set in the same cycle.
   always_comb begin
      w_ovf_rd_clr = CLEAR_ON_READ && bus.rd_en && (bus.rd_addr == OVF_ADDR);
      if (bus.clear_all) begin
         w_ovf_next = '0;
      end else if (w_ovf_rd_clr) begin
         w_ovf_next = w_ovf_set;
      end else begin
         w_ovf_next = r_ovf | w_ovf_set;
      end
   end

   // Read decode on pre-update register values; reserved addresses read 0.
   always_comb begin
      w_rd_mux = '0;
      for (int i = 0; i < NUM_EVENTS; i++) begin
         if (bus.rd_addr == ADDR_WIDTH'(i)) begin
            w_rd_mux = r_cnt[i];
         end
      end
      if (bus.rd_addr == OVF_ADDR) begin
         w_rd_mux = COUNTER_WIDTH'(r_ovf);
      end
   end

   // LED stretch: reload on any masked event, otherwise count down to 0.
   always_comb begin
      w_stretch_next = r_stretch;
      if (|(bus.event_in & EV_MASK)) begin
         w_stretch_next = STRETCH_W'(LED_STRETCH);
      end else if (r_stretch != '0) begin
         w_stretch_next = r_stretch - STRETCH_W'(1);
      end
   end

   // State registers. The LED register samples the next stretch value so the
   // LED rises one cycle after the event and stays on LED_STRETCH cycles.
   always_ff @(posedge clock125 or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_EVENTS; i++) begin
            r_cnt[i] <= '0;
         end
         r_ovf      <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_stretch  <= '0;
         r_led      <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_EVENTS; i++) begin
            r_cnt[i] <= w_cnt_next[i];
         end
         r_ovf      <= w_ovf_next;
         r_rd_valid <= bus.rd_en;
         if (bus.rd_en) begin
            r_rd_data <= w_rd_mux;
         end
         r_stretch  <= w_stretch_next;
         r_led      <= (w_stretch_next != '0);
      end
   end

   assign bus.rd_data      = r_rd_data;
   assign bus.rd_valid     = r_rd_valid;
   assign bus.overflow     = r_ovf;
   assign bus.activity_led = r_led;

endmodule

// File: tb/tb_ethernet_stats_counters.sv
// ---------------------------------------------------------------------------
// tb_ethernet_stats_counters
// Two instances share one stimulus stream:
//   A: 8-bit counters, saturating, clear-on-read, LED stretch 4
//   B: 8-bit counters, wrapping, no clear-on-read, LED stretch 3
// The driver updates a reference model and queues expected read data; a
// separate monitor pops and compares whenever rd_valid is seen.
// ---------------------------------------------------------------------------
module tb_ethernet_stats_counters;

   localparam int unsigned NE    = 9;
   localparam int unsigned CW    = 8;
   localparam int unsigned AW    = 4;
   localparam bit          SAT_A = 1'b1;
   localparam bit          COR_A = 1'b1;
   localparam bit          SAT_B = 1'b0;
   localparam bit          COR_B = 1'b0;
   localparam int          LS_A  = 4;
   localparam int          LS_B  = 3;
   localparam logic [8:0]  MASK  = 9'h104;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #4 clk = ~clk;

   ethernet_stats_counters_if #(.NUM_EVENTS(NE), .COUNTER_WIDTH(CW), .ADDR_WIDTH(AW)) ifa ();
   ethernet_stats_counters_if #(.NUM_EVENTS(NE), .COUNTER_WIDTH(CW), .ADDR_WIDTH(AW)) ifb ();

   ethernet_stats_counters #(
      .NUM_EVENTS(NE), .COUNTER_WIDTH(CW), .ADDR_WIDTH(AW), .SATURATE(SAT_A),
      .CLEAR_ON_READ(COR_A), .LED_MASK(32'h104), .LED_STRETCH(LS_A)
   ) u_dut_a (.clock125(clk), .reset(rst), .bus(ifa));

   ethernet_stats_counters #(
      .NUM_EVENTS(NE), .COUNTER_WIDTH(CW), .ADDR_WIDTH(AW), .SATURATE(SAT_B),
      .CLEAR_ON_READ(COR_B), .LED_MASK(32'h104), .LED_STRETCH(LS_B)
   ) u_dut_b (.clock125(clk), .reset(rst), .bus(ifb));

   // Reference model state
   int unsigned m_cnt [2][NE];
   logic [8:0]  m_ovf [2];
   logic        exp_led [2];
   int unsigned last_rd [2];
   int          step_n;
   int          last_masked;
   bit          have_masked;
   int unsigned qa [$];
   int unsigned qb [$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int inst, input longint act, input longint expv);
      n_checks++;
      if (act == expv) n_pass++;
      else $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h (t=%0t)", name, inst, act, expv, $time);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NE; i++) m_cnt[k][i] = 0;
         m_ovf[k]   = '0;
         exp_led[k] = 1'b0;
         last_rd[k] = 0;
      end
      have_masked = 1'b0;
      qa.delete();
      qb.delete();
   endtask

   function automatic int unsigned model_read(input int inst, input logic [3:0] addr);
      if (int'(addr) < NE) return m_cnt[inst][int'(addr)];
      if (int'(addr) == NE) return int'(m_ovf[inst]);
      return 0;
   endfunction

   task automatic model_step(input int inst, input logic [8:0] ev, input logic clr,
                             input logic rden, input logic [3:0] addr);
      bit sat;
      bit cor;
      logic [8:0] set_now;
      sat     = (inst == 0) ? SAT_A : SAT_B;
      cor     = (inst == 0) ? COR_A : COR_B;
      set_now = '0;
      for (int i = 0; i < NE; i++) begin
         int unsigned c;
         c = m_cnt[inst][i];
         if (clr || (cor && rden && int'(addr) == i)) c = 0;
         if (ev[i]) begin
            if (c == 255) begin
               set_now[i] = 1'b1;
               c = sat ? 255 : 0;
            end else begin
               c = c + 1;
            end
         end
         m_cnt[inst][i] = c;
      end
      if (clr) m_ovf[inst] = '0;
      else if (cor && rden && int'(addr) == NE) m_ovf[inst] = set_now;
      else m_ovf[inst] = m_ovf[inst] | set_now;
   endtask

   task automatic drive(input logic [8:0] ev, input logic clr, input logic rden, input logic [3:0] addr);
      ifa.event_in = ev;  ifa.clear_all = clr;  ifa.rd_en = rden;  ifa.rd_addr = addr;
      ifb.event_in = ev;  ifb.clear_all = clr;  ifb.rd_en = rden;  ifb.rd_addr = addr;
   endtask

   // One clock of stimulus; model state afterwards equals DUT state after the next edge.
   task automatic step(input logic [8:0] ev, input logic clr, input logic rden, input logic [3:0] addr);
      @(negedge clk);
      drive(ev, clr, rden, addr);
      if (rden) begin
         qa.push_back(model_read(0, addr));
         qb.push_back(model_read(1, addr));
      end
      model_step(0, ev, clr, rden, addr);
      model_step(1, ev, clr, rden, addr);
      step_n++;
      if (|(ev & MASK)) begin
         have_masked = 1'b1;
         last_masked = step_n;
      end
      exp_led[0] = have_masked && ((step_n - last_masked) < LS_A);
      exp_led[1] = have_masked && ((step_n - last_masked) < LS_B);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(9'h000, 1'b0, 1'b0, 4'd0);
   endtask

   task automatic check_inst(input int inst, input logic rv, input logic [7:0] rd,
                             input logic [8:0] ov, input logic led);
      int unsigned expv;
      int          qsz;
      if (rst) begin
         check("rst_rd_valid", inst, rv, 0);
         check("rst_rd_data", inst, rd, 0);
         check("rst_overflow", inst, ov, 0);
         check("rst_led", inst, led, 0);
         return;
      end
      qsz = (inst == 0) ? qa.size() : qb.size();
      if (rv) begin
         if (qsz == 0) begin
            check("unexpected_rd_valid", inst, 1, 0);
         end else begin
            expv = (inst == 0) ? qa.pop_front() : qb.pop_front();
            check("rd_data", inst, rd, expv);
            last_rd[inst] = expv;
         end
      end else begin
         check("rd_data_hold", inst, rd, last_rd[inst]);
      end
      check("overflow", inst, ov, m_ovf[inst]);
      check("activity_led", inst, led, exp_led[inst]);
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         check_inst(0, ifa.rd_valid, ifa.rd_data, ifa.overflow, ifa.activity_led);
         check_inst(1, ifb.rd_valid, ifb.rd_data, ifb.overflow, ifb.activity_led);
      end
   end

   initial begin
      step_n      = 0;
      last_masked = 0;
      drive(9'h000, 1'b0, 1'b0, 4'd0);
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Basic count and read
      repeat (3) step(9'h020, 1'b0, 1'b0, 4'd0);
      step(9'h000, 1'b0, 1'b1, 4'd5);
      step(9'h000, 1'b0, 1'b1, 4'd4);
      idle(2);

      // Top value: saturate (A) vs wrap (B), overflow flag and its read
      repeat (260) step(9'h001, 1'b0, 1'b0, 4'd0);
      step(9'h000, 1'b0, 1'b1, 4'd0);
      step(9'h000, 1'b0, 1'b1, 4'd9);
      step(9'h000, 1'b0, 1'b1, 4'd9);
      idle(2);

      // Read with an event in the same cycle
      repeat (10) step(9'h004, 1'b0, 1'b0, 4'd0);
      step(9'h004, 1'b0, 1'b1, 4'd2);
      step(9'h000, 1'b0, 1'b1, 4'd2);
      idle(2);

      // clear_all with a same-cycle read, then sweep every address
      repeat (7) step(9'h002, 1'b0, 1'b0, 4'd0);
      step(9'h000, 1'b1, 1'b1, 4'd1);
      for (int a = 0; a < 16; a++) step(9'h000, 1'b0, 1'b1, 4'(a));
      idle(2);

      // LED: masked pulse stretches, unmasked pulse does not
      step(9'h100, 1'b0, 1'b0, 4'd0);
      idle(6);
      step(9'h001, 1'b0, 1'b0, 4'd0);
      idle(6);

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         logic [8:0] ev;
         logic       clr;
         logic       rden;
         logic [3:0] addr;
         ev   = 9'($urandom) & 9'($urandom);
         clr  = ($urandom_range(0, 49) == 0);
         rden = 1'($urandom_range(0, 1));
         addr = 4'($urandom_range(0, 15));
         step(ev, clr, rden, addr);
      end
      idle(2);

      // Asynchronous reset while a read is pending
      @(negedge clk);
      drive(9'h1FF, 1'b0, 1'b1, 4'd3);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_valid", 0, ifa.rd_valid, 0);
      check("async_rst_data", 0, ifa.rd_data, 0);
      check("async_rst_ovf", 0, ifa.overflow, 0);
      check("async_rst_led", 0, ifa.activity_led, 0);
      check("async_rst_valid", 1, ifb.rd_valid, 0);
      check("async_rst_data", 1, ifb.rd_data, 0);
      check("async_rst_ovf", 1, ifb.overflow, 0);
      check("async_rst_led", 1, ifb.activity_led, 0);
      model_reset();
      drive(9'h000, 1'b0, 1'b0, 4'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      step(9'h000, 1'b0, 1'b1, 4'd9);
      idle(3);

      check("queue_drained", 0, qa.size(), 0);
      check("queue_drained", 1, qb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ethernet_stats_counters.md
Name: ethernet_stats_counters

Overview:
Parametrised statistics block that consumes the per-frame status pulses produced by the 1G MAC wrapper (tx/rx FIFO overflow, bad/good frame, underflow, bad FCS, ...). It accumulates each pulse into its own counter and exposes the counts through a simple addressed read port with optional clear-on-read. It also keeps sticky overflow flags and drives a pulse-stretched activity LED. It sits in the 125 MHz MAC logic domain between the MAC wrapper status outputs and the MMIO/debug fabric.

Parameters:
NUM_EVENTS, 9, number of event inputs/counters (1..32)
COUNTER_WIDTH, 32, width of each counter and of rd_data (8..64; must be >= NUM_EVENTS)
ADDR_WIDTH, 4, read address width; 2**ADDR_WIDTH must be > NUM_EVENTS
SATURATE, 1, 1 = counters stick at all-ones; 0 = counters wrap to 0
CLEAR_ON_READ, 0, 1 = a counter read clears that counter
LED_MASK, 9'h104, events that retrigger the activity LED (default: tx good frame bit 2, rx good frame bit 8)
LED_STRETCH, 6250000, LED on-time in clock125 cycles after the last masked event (50 ms); must be >= 1

Ports:
clock125  input  1  block clock, 125 MHz
reset  input  1  asynchronous, active-high reset
event_in  input  NUM_EVENTS  single-cycle event pulses, synchronous to clock125
clear_all  input  1  synchronous clear of all counters and overflow flags
rd_en  input  1  read request strobe
rd_addr  input  ADDR_WIDTH  0..NUM_EVENTS-1 = counter; NUM_EVENTS = overflow vector; above that = reserved
rd_data  output  COUNTER_WIDTH  read result
rd_valid  output  1  one-cycle strobe qualifying rd_data
overflow  output  NUM_EVENTS  sticky per-counter overflow/saturation flags
activity_led  output  1  stretched activity indicator

Behaviour:
- Reset (async assert, release sync to clock125): all counters 0, overflow 0, rd_data 0, rd_valid 0, LED stretch counter 0, activity_led 0.
- Count: each cycle event_in[i]=1 increments counter[i] by exactly 1. Level-high for k cycles counts k.
- Top value: at all-ones with event_in[i]=1:
  - SATURATE=1: counter holds all-ones.
  - SATURATE=0: counter wraps to 0.
  - Either mode: overflow[i] is set the next cycle and stays set until cleared.
- Read latency 1: rd_en in cycle N gives rd_valid=1 in cycle N+1. rd_data holds the value the register had at the start of cycle N, i.e. before any cycle-N increment.
  - rd_valid is high for exactly one cycle per rd_en. Back-to-back reads are allowed every cycle.
  - rd_data holds its last value while rd_valid=0.
- Address decode: rd_addr=NUM_EVENTS returns overflow zero-extended to COUNTER_WIDTH. Reserved addresses return 0 with rd_valid still asserted.
- Clear-on-read (CLEAR_ON_READ=1):
  - Reading counter i loads it with event_in[i] (0 or 1) in the same edge, so no event is lost.
  - Reading address NUM_EVENTS clears overflow, except bits being newly set in that same cycle.
  - CLEAR_ON_READ=0: reads have no side effects.
- clear_all: counters load event_in (0 or 1) and overflow clears to 0. A read issued in the same cycle returns the pre-clear value.
- Priority per counter per cycle: clear_all / clear-on-read load, then increment, then saturate/wrap. A clear and an event in the same cycle gives 1.
- Activity LED: if |(event_in & LED_MASK), the stretch counter loads LED_STRETCH; otherwise it decrements toward 0 and holds at 0.
  - activity_led = (stretch counter != 0), registered.
  - LED goes high 1 cycle after a masked event and stays high exactly LED_STRETCH cycles after the last masked event.
- Reset mid-operation: everything returns to reset values immediately. A read in flight is dropped and produces no rd_valid.

Test Plan:
- Reset, then pulse event_in[5] for 3 cycles, then rd_en with rd_addr=5 -> rd_valid for 1 cycle, rd_data=3; rd_addr=4 -> 0.
- SATURATE=1, COUNTER_WIDTH=8: 260 pulses on event 0 -> counter reads 255, overflow[0]=1. SATURATE=0: same stimulus -> reads 4, overflow[0]=1.
- CLEAR_ON_READ=1: count 10 on event 2, then rd_addr=2 with event_in[2]=1 in the same cycle -> rd_data=10; a second read returns 1.
- 7 events on counter 1, then clear_all together with rd_en at rd_addr=1 -> rd_data=7; all counters read 0 and overflow=0 afterwards.
- LED_STRETCH=4: one pulse on event 8 -> activity_led high for exactly 4 cycles starting 1 cycle later. Pulse on event 0 (unmasked) -> LED stays low.
- Assert reset asynchronously while rd_en is pending -> no rd_valid, all outputs 0; rd_addr=NUM_EVENTS after release -> rd_data=0.
